// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline-stage register:
// occupancy state encoding and the ID/EX control-bundle bit layout.
package pipe_pkg;

    // State is the pair {main valid, skid valid}.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    // Bit offsets of the ID/EX control bundle as packed by the decoder.
    localparam int CTRL_REG_WRITE = 0;
    localparam int CTRL_WED       = 1;
    localparam int CTRL_BRANCH    = 2;
    localparam int CTRL_JMP       = 3;
    localparam int CTRL_JMPR      = 4;
    localparam int CTRL_ALUSRC    = 5;
    localparam int CTRL_RES_SRC   = 6;   // two bits: 6..7
    localparam int CTRL_RES_SRC_W = 2;
    localparam int CTRL_LUI       = 8;
    localparam int CTRL_AUIPC     = 9;

    // Decode the two slot valid bits into the stage state.
    // A lone skid entry cannot occur; it is folded into EMPTY.
    function automatic state_t state_of(input logic main_v, input logic skid_v);
        state_t st;
        if (main_v && skid_v) begin
            st = ST_FULL;
        end else if (main_v) begin
            st = ST_ONE;
        end else begin
            st = ST_EMPTY;
        end
        return st;
    endfunction

endpackage

// File: rtl/pipe_stage_hs_if.sv
// Valid/ready handshake bundle carrying a payload and a control bundle.
// master drives valid/data/ctrl, slave drives ready.
interface pipe_stage_hs_if #(
    parameter int DATA_W = 192,
    parameter int CTRL_W = 16
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_slot.sv
// One storage slot of the stage: payload, control bundle and valid bit.
// clear has priority over load; a cleared slot always shows CTRL_RST so a
// bubble can never carry a stale write enable.
module pipe_slot #(
    parameter int              DATA_W     = 192,
    parameter int              CTRL_W     = 16,
    parameter logic [CTRL_W-1:0] CTRL_RST = '0,
    parameter bit              CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

    // Next-slot contents: clear beats load, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_RST;
            if (CLEAR_DATA) begin
                data_d = '0;
            end
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    // Slot register with asynchronous reset to the bubble value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= CTRL_RST;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline-stage register. With SKID=1 a second slot absorbs the
// entry that arrives while the head is stalled, so in_ready can be a flop
// without losing throughput. With SKID=0 a single slot is used and in_ready
// is combinational. flush empties the stage and drops the current input.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 192,
    parameter int                CTRL_W     = 16,
    parameter logic [CTRL_W-1:0] CTRL_RST   = '0,
    parameter bit                CLEAR_DATA = 1'b1,
    parameter bit                SKID       = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    pipe_stage_hs_if.slave     in_if,
    pipe_stage_hs_if.master    out_if,
    output logic [1:0]         occupancy
);

    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_din;
    logic [CTRL_W-1:0] main_cin;
    logic              main_v;

    pipe_slot #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .CTRL_RST   (CTRL_RST),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (main_load),
        .clear_i (main_clear),
        .data_i  (main_din),
        .ctrl_i  (main_cin),
        .valid_o (main_v),
        .data_o  (out_if.data),
        .ctrl_o  (out_if.ctrl)
    );

    assign out_if.valid = main_v;

    if (SKID) begin : g_skid
        logic              skid_load;
        logic              skid_clear;
        logic              skid_v;
        logic [DATA_W-1:0] skid_data;
        logic [CTRL_W-1:0] skid_ctrl;
        logic              in_ready_q, in_ready_d;
        logic              accept, transfer;
        state_t            state_cur, state_d;

        // The skid slot only ever takes the upstream entry.
        pipe_slot #(
            .DATA_W     (DATA_W),
            .CTRL_W     (CTRL_W),
            .CTRL_RST   (CTRL_RST),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_skid (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (skid_load),
            .clear_i (skid_clear),
            .data_i  (in_if.data),
            .ctrl_i  (in_if.ctrl),
            .valid_o (skid_v),
            .data_o  (skid_data),
            .ctrl_o  (skid_ctrl)
        );

        assign state_cur = state_of(main_v, skid_v);
        assign accept    = in_if.valid & in_ready_q;
        assign transfer  = main_v & out_if.ready;

        // Next state and slot controls; the skid entry only moves into main,
        // never straight out, which keeps ordering strictly FIFO.
        always_comb begin
            state_d    = state_cur;
            main_load  = 1'b0;
            main_clear = 1'b0;
            skid_load  = 1'b0;
            skid_clear = 1'b0;
            main_din   = in_if.data;
            main_cin   = in_if.ctrl;
            if (flush) begin
                state_d    = ST_EMPTY;
                main_clear = 1'b1;
                skid_clear = 1'b1;
            end else begin
                case (state_cur)
                    ST_EMPTY: begin
                        if (accept) begin
                            main_load = 1'b1;
                            state_d   = ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && transfer) begin
                            main_load = 1'b1;
                        end else if (accept) begin
                            skid_load = 1'b1;
                            state_d   = ST_FULL;
                        end else if (transfer) begin
                            main_clear = 1'b1;
                            state_d    = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (transfer) begin
                            main_load  = 1'b1;
                            main_din   = skid_data;
                            main_cin   = skid_ctrl;
                            skid_clear = 1'b1;
                            state_d    = ST_ONE;
                        end
                    end
                    default: begin
                        main_clear = 1'b1;
                        skid_clear = 1'b1;
                        state_d    = ST_EMPTY;
                    end
                endcase
            end
            in_ready_d = (state_d != ST_FULL);
        end

        // Registered in_ready: open whenever the next state leaves room.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= in_ready_d;
            end
        end

        assign in_if.ready = in_ready_q;
        assign occupancy   = {1'b0, main_v} + {1'b0, skid_v};
    end else begin : g_noskid
        logic in_ready_c;
        logic accept, transfer;

        assign in_ready_c  = ~main_v | out_if.ready;
        assign in_if.ready = in_ready_c;
        assign accept      = in_if.valid & in_ready_c;
        assign transfer    = main_v & out_if.ready;
        assign main_din    = in_if.data;
        assign main_cin    = in_if.ctrl;

        // Single slot: flush clears, accept reloads, a lone transfer empties.
        always_comb begin
            main_load  = 1'b0;
            main_clear = 1'b0;
            if (flush) begin
                main_clear = 1'b1;
            end else if (accept) begin
                main_load = 1'b1;
            end else if (transfer) begin
                main_clear = 1'b1;
            end
        end

        assign occupancy = {1'b0, main_v};
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: DUT A (SKID=1, CLEAR_DATA=1) and DUT B (SKID=0,
// CLEAR_DATA=0, nonzero CTRL_RST) are driven in lockstep. A FIFO model per
// DUT supplies the expected head entry, occupancy and in_ready every cycle.
module tb_pipe_stage_hs;

    localparam logic [15:0] A_CTRL_RST = 16'h0000;
    localparam logic [7:0]  B_CTRL_RST = 8'hC0;

    logic clk;
    logic rst_n;
    logic a_flush, b_flush;
    logic [1:0] occ_a, occ_b;

    pipe_stage_hs_if #(.DATA_W(192), .CTRL_W(16)) a_in ();
    pipe_stage_hs_if #(.DATA_W(192), .CTRL_W(16)) a_out ();
    pipe_stage_hs_if #(.DATA_W(32),  .CTRL_W(8))  b_in ();
    pipe_stage_hs_if #(.DATA_W(32),  .CTRL_W(8))  b_out ();

    pipe_stage_hs #(
        .DATA_W(192), .CTRL_W(16), .CTRL_RST(A_CTRL_RST), .CLEAR_DATA(1'b1), .SKID(1'b1)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush),
        .in_if(a_in), .out_if(a_out), .occupancy(occ_a)
    );

    pipe_stage_hs #(
        .DATA_W(32), .CTRL_W(8), .CTRL_RST(B_CTRL_RST), .CLEAR_DATA(1'b0), .SKID(1'b0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_if(b_in), .out_if(b_out), .occupancy(occ_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int b_out_cnt = 0;
    int a_xfer_total = 0;
    int b_xfer_total = 0;
    bit verbose = 1'b1;

    // Model queues hold {ctrl, data} zero-extended to 256 bits.
    logic [255:0] qa[$];
    logic [255:0] qb[$];

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: called at posedge+1, drives inputs, checks the DUT
    // state against the models, advances the models, returns at next posedge+1.
    task automatic step(
        input  logic va, input logic [191:0] da, input logic [15:0] ca, input logic ra, input logic fa,
        input  logic vb, input logic [31:0]  db, input logic [7:0]  cb, input logic rb, input logic fb,
        output logic acc_a, output logic acc_b
    );
        logic xfer_a, xfer_b;
        a_in.valid = va; a_in.data = da; a_in.ctrl = ca; a_out.ready = ra; a_flush = fa;
        b_in.valid = vb; b_in.data = db; b_in.ctrl = cb; b_out.ready = rb; b_flush = fb;
        #1;
        check_eq("a.out_valid", a_out.valid, qa.size() != 0);
        if (qa.size() != 0) begin
            check_eq("a.out_data", a_out.data, qa[0][191:0]);
            check_eq("a.out_ctrl", a_out.ctrl, qa[0][207:192]);
        end else begin
            check_eq("a.idle_ctrl", a_out.ctrl, A_CTRL_RST);
        end
        check_eq("a.occupancy", occ_a, qa.size());
        check_eq("a.in_ready", a_in.ready, qa.size() != 2);
        check_eq("b.out_valid", b_out.valid, qb.size() != 0);
        if (qb.size() != 0) begin
            check_eq("b.out_data", b_out.data, qb[0][31:0]);
            check_eq("b.out_ctrl", b_out.ctrl, qb[0][39:32]);
        end else begin
            check_eq("b.idle_ctrl", b_out.ctrl, B_CTRL_RST);
        end
        check_eq("b.occupancy", occ_b, qb.size());
        check_eq("b.in_ready", b_in.ready, (qb.size() == 0) || rb);
        if (b_out.valid && rb) b_out_cnt++;

        acc_a  = va && (qa.size() != 2);
        xfer_a = (qa.size() != 0) && ra;
        acc_b  = vb && ((qb.size() == 0) || rb);
        xfer_b = (qb.size() != 0) && rb;
        if (xfer_a) begin
            a_xfer_total++;
            if (verbose) $display("A out data=%h ctrl=%h", qa[0][191:0], qa[0][207:192]);
            void'(qa.pop_front());
        end
        if (xfer_b) begin
            b_xfer_total++;
            if (verbose) $display("B out data=%h ctrl=%h", qb[0][31:0], qb[0][39:32]);
            void'(qb.pop_front());
        end
        if (fa) qa.delete();
        else if (acc_a) qa.push_back({48'b0, ca, da});
        if (fb) qb.delete();
        else if (acc_b) qb.push_back({216'b0, cb, db});
        if (fa) acc_a = 1'b0;
        if (fb) acc_b = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // A-only cycle with B idle (B ready held high).
    task automatic step_a(input logic va, input logic [191:0] da, input logic [15:0] ca,
                          input logic ra, input logic fa);
        logic x, y;
        step(va, da, ca, ra, fa, 1'b0, 32'h0, 8'h0, 1'b1, 1'b0, x, y);
    endtask

    // B-only cycle with A idle (A ready held high).
    task automatic step_b(input logic vb, input logic [31:0] db, input logic [7:0] cb,
                          input logic rb, input logic fb);
        logic x, y;
        step(1'b0, 192'h0, 16'h0, 1'b1, 1'b0, vb, db, cb, rb, fb, x, y);
    endtask

    logic [191:0] d_a5;
    logic [191:0] pa_d;
    logic [15:0]  pa_c;
    logic [31:0]  pb_d;
    logic [7:0]   pb_c;
    logic         pa_v, pb_v, pa_acc, pb_acc;
    int           b_cnt0;

    initial begin
        rst_n = 1'b0;
        a_in.valid = 1'b0; a_in.data = '0; a_in.ctrl = '0; a_out.ready = 1'b0; a_flush = 1'b0;
        b_in.valid = 1'b0; b_in.data = '0; b_in.ctrl = '0; b_out.ready = 1'b0; b_flush = 1'b0;
        d_a5 = {24{8'hA5}};

        // Reset values while rst_n is held low.
        @(posedge clk); #1;
        check_eq("rst.a_valid", a_out.valid, 1'b0);
        check_eq("rst.a_ctrl", a_out.ctrl, A_CTRL_RST);
        check_eq("rst.a_data", a_out.data, 192'h0);
        check_eq("rst.a_occ", occ_a, 2'd0);
        check_eq("rst.a_ready", a_in.ready, 1'b1);
        check_eq("rst.b_valid", b_out.valid, 1'b0);
        check_eq("rst.b_ctrl", b_out.ctrl, B_CTRL_RST);
        check_eq("rst.b_ready", b_in.ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: single entry passes with one cycle of latency.
        step_a(1'b1, d_a5, 16'h0003, 1'b1, 1'b0);
        check_eq("t1.valid", a_out.valid, 1'b1);
        check_eq("t1.data", a_out.data, d_a5);
        check_eq("t1.ctrl", a_out.ctrl, 16'h0003);
        check_eq("t1.occ", occ_a, 2'd1);
        step_a(1'b0, '0, '0, 1'b1, 1'b0);
        step_a(1'b0, '0, '0, 1'b1, 1'b0);

        // 2: stall fills main then skid; D3 waits upstream; drain is in order.
        step_a(1'b1, 192'hD1, 16'h0011, 1'b0, 1'b0);
        step_a(1'b1, 192'hD2, 16'h0012, 1'b0, 1'b0);
        check_eq("t2.occ_full", occ_a, 2'd2);
        check_eq("t2.ready_full", a_in.ready, 1'b0);
        step_a(1'b1, 192'hD3, 16'h0013, 1'b0, 1'b0);
        check_eq("t2.hold_head", a_out.data, 192'hD1);
        step_a(1'b1, 192'hD3, 16'h0013, 1'b1, 1'b0);
        check_eq("t2.second", a_out.data, 192'hD2);
        step_a(1'b1, 192'hD3, 16'h0013, 1'b1, 1'b0);
        check_eq("t2.third", a_out.data, 192'hD3);
        step_a(1'b0, '0, '0, 1'b1, 1'b0);
        step_a(1'b0, '0, '0, 1'b1, 1'b0);

        // 3: flush while FULL with a live input; B flushed while holding E1.
        step(1'b1, 192'hF1, 16'h0021, 1'b0, 1'b0, 1'b1, 32'hE1, 8'h05, 1'b0, 1'b0, pa_acc, pb_acc);
        step(1'b1, 192'hF2, 16'h0022, 1'b0, 1'b0, 1'b1, 32'hE2, 8'h06, 1'b0, 1'b0, pa_acc, pb_acc);
        step(1'b1, 192'hF3, 16'h0023, 1'b0, 1'b1, 1'b1, 32'hE2, 8'h06, 1'b0, 1'b1, pa_acc, pb_acc);
        check_eq("t3.a_valid", a_out.valid, 1'b0);
        check_eq("t3.a_ctrl", a_out.ctrl, A_CTRL_RST);
        check_eq("t3.a_data_zero", a_out.data, 192'h0);
        check_eq("t3.a_occ", occ_a, 2'd0);
        check_eq("t3.a_ready", a_in.ready, 1'b1);
        check_eq("t3.b_valid", b_out.valid, 1'b0);
        check_eq("t3.b_ctrl", b_out.ctrl, B_CTRL_RST);
        check_eq("t3.b_data_held", b_out.data, 32'hE1);
        // Flush coinciding with an accept into an empty B: entry dropped.
        step_b(1'b1, 32'hE3, 8'h07, 1'b1, 1'b1);
        check_eq("t3.b_drop", b_out.valid, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, pa_acc, pb_acc);

        // 5: asynchronous reset in the middle of a FULL cycle.
        step_a(1'b1, 192'hC1, 16'h0031, 1'b0, 1'b0);
        step_a(1'b1, 192'hC2, 16'h0032, 1'b0, 1'b0);
        a_in.valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5.valid", a_out.valid, 1'b0);
        check_eq("t5.ctrl", a_out.ctrl, A_CTRL_RST);
        check_eq("t5.data", a_out.data, 192'h0);
        check_eq("t5.occ", occ_a, 2'd0);
        check_eq("t5.ready", a_in.ready, 1'b1);
        qa.delete();
        qb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step_a(1'b1, 192'hB0, 16'h0041, 1'b1, 1'b0);
        check_eq("t5.first_out", a_out.data, 192'hB0);
        step_a(1'b0, '0, '0, 1'b1, 1'b0);

        // 6: SKID=0 streams 8 entries in 8 cycles; in_ready tracks out_ready.
        b_cnt0 = b_out_cnt;
        for (int k = 0; k < 8; k++) begin
            step_b(1'b1, 32'h100 + 32'(k), 8'(k), 1'b1, 1'b0);
        end
        step_b(1'b0, '0, '0, 1'b1, 1'b0);
        check_eq("t6.count", b_out_cnt - b_cnt0, 8);
        step_b(1'b1, 32'h200, 8'h09, 1'b0, 1'b0);
        b_out.ready = 1'b0;
        #1 check_eq("t6.ready_lo", b_in.ready, 1'b0);
        b_out.ready = 1'b1;
        #1 check_eq("t6.ready_hi", b_in.ready, 1'b1);
        step_b(1'b0, '0, '0, 1'b1, 1'b0);
        step_b(1'b0, '0, '0, 1'b1, 1'b0);

        // 4: random valid/ready on both DUTs, inputs held while stalled.
        verbose = 1'b0;
        a_xfer_total = 0;
        b_xfer_total = 0;
        pa_v = 1'b0; pb_v = 1'b0; pa_acc = 1'b1; pb_acc = 1'b1;
        pa_d = '0; pa_c = '0; pb_d = '0; pb_c = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!pa_v || pa_acc) begin
                pa_v = 1'($urandom_range(0, 1));
                for (int w = 0; w < 6; w++) pa_d[w*32 +: 32] = $urandom();
                pa_c = 16'($urandom());
            end
            if (!pb_v || pb_acc) begin
                pb_v = 1'($urandom_range(0, 1));
                pb_d = {16'(i), 16'($urandom())};
                pb_c = 8'($urandom());
            end
            step(pa_v, pa_d, pa_c, 1'($urandom_range(0, 1)), 1'b0,
                 pb_v, pb_d, pb_c, 1'($urandom_range(0, 1)), 1'b0, pa_acc, pb_acc);
        end
        $display("random run: %0d entries out of A, %0d entries out of B", a_xfer_total, b_xfer_total);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
